// File: rtl/hca_sub_pipe.sv
// hca_sub_pipe: three-stage pipelined subtractor (A - B) built on a
// Han-Carlson prefix carry tree, with valid/ready handshakes on both sides.
// The pipeline is a global-stall design: every stage advances together or
// holds together, so bubbles are preserved rather than collapsed.
module hca_sub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int DEPTH = $clog2(WIDTH);

    // Kogge-Stone style prefix over the odd bits only. Level 1 pairs each odd
    // bit with its even neighbour; later levels have even spans, so odd bits
    // combine only with odd bits. After DEPTH levels each odd bit holds the
    // full group generate down to bit 0, where the carry-in is folded in.
    function automatic logic [WIDTH-1:0] odd_tree(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g_cur;
        logic [WIDTH-1:0] p_cur;
        logic [WIDTH-1:0] g_nxt;
        logic [WIDTH-1:0] p_nxt;
        int               span;
        g_cur = g_in;
        p_cur = p_in;
        for (int j = 1; j <= DEPTH; j++) begin
            span  = 1 << (j - 1);
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 1; i < WIDTH; i += 2) begin
                if (i >= span) begin
                    g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - span]);
                    p_nxt[i] = p_cur[i] & p_cur[i - span];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        return g_cur;
    endfunction

    // Stage registers
    logic             v1_q, v2_q, v3_q;
    logic [WIDTH-1:0] p1_q, g1_q;
    logic             a_msb1_q, b_msb1_q;
    logic [WIDTH-1:0] p2_q, g2_q;
    logic             a_msb2_q, b_msb2_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, zero_q, ovf_q;

    // Next-state values
    logic [WIDTH-1:0] p1_d, g1_d;
    logic [WIDTH-1:0] g2_d;
    logic [WIDTH-1:0] g_full;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_d, zero_d, ovf_d;
    logic             adv;

    // One shared advance enable: the whole pipe moves unless the output is stuck.
    assign adv      = !v3_q || out_ready;
    assign in_ready = adv;

    // Pre-process for A + ~B + 1, with the carry-in absorbed into bit 0.
    always_comb begin
        p1_d    = A ^ ~B;
        g1_d    = A & ~B;
        g1_d[0] = A[0] | ~B[0];
    end

    // Odd-bit prefix tree between S1 and S2.
    always_comb begin
        g2_d = odd_tree(g1_q, p1_q);
    end

    // Even-bit fix-up level, sum, and status flags between S2 and S3.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
        g_full = g2_q;
        diff_d = '0;
        for (int i = 2; i < WIDTH; i += 2) begin
            g_full[i] = g2_q[i] | (p2_q[i] & g2_q[i - 1]);
        end
        diff_d[0] = ~p2_q[0];
        for (int i = 1; i < WIDTH; i++) begin
            diff_d[i] = p2_q[i] ^ g_full[i - 1];
        end
        borrow_d = ~g_full[WIDTH-1];
        zero_d   = (diff_d == '0);
        ovf_d    = (a_msb2_q != b_msb2_q) && (diff_d[WIDTH-1] != a_msb2_q);
    end

    // Control and result registers: cleared by reset, otherwise shift on adv.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            v1_q     <= in_valid && in_ready;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Intermediate datapath registers: shift on adv, qualified by the valid bits.
    always_ff @(posedge clk) begin
        // NOTE: these carry no reset; their contents are meaningless until the matching valid bit is set.
        if (adv) begin
            p1_q     <= p1_d;
            g1_q     <= g1_d;
            a_msb1_q <= A[WIDTH-1];
            b_msb1_q <= B[WIDTH-1];
            p2_q     <= p1_q;
            g2_q     <= g2_d;
            a_msb2_q <= a_msb1_q;
            b_msb2_q <= b_msb1_q;
        end
    end

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hca_sub_pipe.sv
// tb_hca_sub_pipe: directed and random checks of hca_sub_pipe at WIDTH=16
// and WIDTH=13. Inputs change on the falling edge; outputs are read on the
// falling edge (plus a settle step for the combinational in_ready).
module tb_hca_sub_pipe;

    localparam int NR = 10000;

    logic        clk;
    logic        rst;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, diff16;
    logic        borrow16, zero16, ovf16;
    logic        iv13, ir13, ov13, or13;
    logic [12:0] a13, b13, diff13;
    logic        borrow13, zero13, ovf13;

    int n_checks;
    int n_err;

    hca_sub_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .out_valid(ov16), .out_ready(or16),
        .diff(diff16), .borrow(borrow16), .zero(zero16), .ovf(ovf16)
    );

    hca_sub_pipe #(.WIDTH(13)) u13 (
        .clk(clk), .rst(rst),
        .in_valid(iv13), .in_ready(ir13), .A(a13), .B(b13),
        .out_valid(ov13), .out_ready(or13),
        .diff(diff13), .borrow(borrow13), .zero(zero13), .ovf(ovf13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {diff, borrow, zero, ovf} for w-bit operands held in 16 bits.
    function automatic logic [18:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input int w);
        logic [15:0] mask;
        logic [15:0] d;
        logic        sa, sb, sd;
        mask = 16'((32'd1 << w) - 32'd1);
        d    = (a - b) & mask;
        sa   = a[w-1];
        sb   = b[w-1];
        sd   = d[w-1];
        return {d, (a < b), (d == '0), (sa != sb) && (sd != sa)};
    endfunction

    // One isolated op on the 16-bit instance with out_ready held high.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ed, input int eb, input int ez, input int eo);
        @(negedge clk);
        iv16 = 1'b1; a16 = a; b16 = b; or16 = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(ir16), 1);
        @(negedge clk);
        iv16 = 1'b0;
        check({tag, "_ov_e1"}, 32'(ov16), 0);
        @(negedge clk);
        check({tag, "_ov_e2"}, 32'(ov16), 0);
        @(negedge clk);
        check({tag, "_ov_e3"}, 32'(ov16), 1);
        check({tag, "_diff"}, 32'(diff16), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow16), eb);
        check({tag, "_zero"}, 32'(zero16), ez);
        check({tag, "_ovf"}, 32'(ovf16), eo);
        @(negedge clk);
        check({tag, "_ov_e4"}, 32'(ov16), 0);
    endtask

    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    logic [15:0] bp_d [5];
    logic [18:0] q16 [$];
    logic [18:0] q13 [$];

    initial begin
        int in_idx, out_idx, stall, sent16, got16, sent13, got13;
        bit first_seen;
        logic [18:0] exp_r;
        n_checks = 0;
        n_err    = 0;
        rst  = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b0;
        iv13 = 1'b0; a13 = '0; b13 = '0; or13 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ov16", 32'(ov16), 0);
        check("rst_diff16", 32'(diff16), 0);
        check("rst_borrow16", 32'(borrow16), 0);
        check("rst_zero16", 32'(zero16), 0);
        check("rst_ovf16", 32'(ovf16), 0);
        check("rst_ov13", 32'(ov13), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready16", 32'(ir16), 1);

        // Directed single ops
        run_one("basic", 16'h1234, 16'h0034, 16'h1200, 0, 0, 0);
        run_one("wrap",  16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
        run_one("equal", 16'hBEEF, 16'hBEEF, 16'h0000, 0, 1, 0);
        run_one("ovf_neg_min", 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1);
        run_one("ovf_pos_max", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1);
        run_one("minus_zero", 16'h0001, 16'h0000, 16'h0001, 0, 0, 0);
        run_one("neg_neg", 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0);

        // Backpressure: five back-to-back ops, 4-cycle stall at first result
        bp_a[0] = 16'h0010; bp_b[0] = 16'h0001; bp_d[0] = 16'h000F;
        bp_a[1] = 16'h0100; bp_b[1] = 16'h0001; bp_d[1] = 16'h00FF;
        bp_a[2] = 16'h1000; bp_b[2] = 16'h0001; bp_d[2] = 16'h0FFF;
        bp_a[3] = 16'h0005; bp_b[3] = 16'h0007; bp_d[3] = 16'hFFFE;
        bp_a[4] = 16'hFFFF; bp_b[4] = 16'hFFFF; bp_d[4] = 16'h0000;
        in_idx = 0; out_idx = 0; stall = 0; first_seen = 1'b0;
        for (int c = 0; c < 40 && out_idx < 5; c++) begin
            @(negedge clk);
            iv16 = (in_idx < 5);
            if (in_idx < 5) begin
                a16 = bp_a[in_idx];
                b16 = bp_b[in_idx];
            end
            if (ov16 && !first_seen) begin
                first_seen = 1'b1;
                stall = 4;
            end
            or16 = (stall == 0);
            #1;
            if (stall > 0) begin
                check("bp_stall_in_ready", 32'(ir16), 0);
                check("bp_stall_out_valid", 32'(ov16), 1);
                check("bp_stall_diff_hold", 32'(diff16), 32'(bp_d[out_idx]));
                stall--;
            end
            if (iv16 && ir16) in_idx++;
            if (ov16 && or16) begin
                check("bp_result", 32'(diff16), 32'(bp_d[out_idx]));
                out_idx++;
            end
        end
        check("bp_accepted", in_idx, 5);
        check("bp_emitted", out_idx, 5);
        @(negedge clk);
        iv16 = 1'b0; or16 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_no_dup", 32'(ov16), 0);
        end

        // Reset while two ops are in flight
        @(negedge clk);
        iv16 = 1'b1; a16 = 16'h0050; b16 = 16'h0010; or16 = 1'b1;
        @(negedge clk);
        a16 = 16'h0060; b16 = 16'h0020;
        @(negedge clk);
        rst = 1'b1; a16 = 16'h0070; b16 = 16'h0030;
        @(negedge clk);
        rst = 1'b0; iv16 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("midrst_no_out", 32'(ov16), 0);
            @(negedge clk);
        end
        run_one("after_rst", 16'h0042, 16'h0002, 16'h0040, 0, 0, 0);

        // Random traffic on both widths with random valid/ready
        sent16 = 0; got16 = 0; sent13 = 0; got13 = 0;
        for (int c = 0; c < 60000 && (got16 < NR || got13 < NR); c++) begin
            @(negedge clk);
            iv16 = (sent16 < NR) && ($urandom_range(3) != 0);
            a16  = 16'($urandom);
            b16  = ($urandom_range(15) == 0) ? a16 : 16'($urandom);
            or16 = ($urandom_range(3) != 0);
            iv13 = (sent13 < NR) && ($urandom_range(3) != 0);
            a13  = 13'($urandom);
            b13  = ($urandom_range(15) == 0) ? a13 : 13'($urandom);
            or13 = ($urandom_range(3) != 0);
            #1;
            if (iv16 && ir16) begin
                q16.push_back(ref_sub(a16, b16, 16));
                sent16++;
            end
            if (iv13 && ir13) begin
                q13.push_back(ref_sub({3'b000, a13}, {3'b000, b13}, 13));
                sent13++;
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    check("rnd16_unexpected", 32'(ov16), 0);
                end else begin
                    exp_r = q16.pop_front();
                    check("rnd16", 32'({diff16, borrow16, zero16, ovf16}), 32'(exp_r));
                end
                got16++;
            end
            if (ov13 && or13) begin
                if (q13.size() == 0) begin
                    check("rnd13_unexpected", 32'(ov13), 0);
                end else begin
                    exp_r = q13.pop_front();
                    check("rnd13", 32'({3'b000, diff13, borrow13, zero13, ovf13}), 32'(exp_r));
                end
                got13++;
            end
        end
        check("rnd16_count", got16, NR);
        check("rnd13_count", got13, NR);
        check("rnd16_leftover", q16.size(), 0);
        check("rnd13_leftover", q13.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
